// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, defaults and helpers for the fp_sqrt_iter square-root unit
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // Canonical quiet NaN for the single-precision default format
    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        NAN,
        NEG
    } op_class_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ITER,
        PACK,
        DONE
    } state_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_sqrt_iter_sqrt_core.sv
// rtl/fp_sqrt_iter_sqrt_core.sv - restoring square-root recurrence, one root bit per enabled cycle
module sqrt_core #(
    parameter int MAN_W = 23,
    localparam int N = MAN_W + 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] radicand,
    output logic [N-2:0] root,
    output logic         rem_nonzero
);

    localparam int RW = N + 3;

    logic [2*N-1:0] x_q;
    logic [RW-1:0]  rem_q;
    logic [N-1:0]   root_q;
    logic [RW-1:0]  shifted;
    logic [RW-1:0]  trial;
    logic           ge;

    // Bring down the next radicand digit pair and try appending a 1 to the root
    always_comb begin
        shifted = {rem_q[RW-3:0], x_q[2*N-1:2*N-2]};
        trial   = {1'b0, root_q, 2'b01};
        ge      = (shifted >= trial);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else if (load) begin
            x_q    <= {radicand, {N{1'b0}}};
            rem_q  <= '0;
            root_q <= '0;
        end else if (en) begin
            x_q    <= {x_q[2*N-3:0], 2'b00};
            rem_q  <= ge ? (shifted - trial) : shifted;
            root_q <= {root_q[N-2:0], ge};
        end
    end

    // The hidden bit is always 1 for a radicand in [1,4), so only fraction+guard leave
    assign root        = root_q[N-2:0];
    assign rem_nonzero = |rem_q;

endmodule

// File: rtl/fp_sqrt_iter.sv
// rtl/fp_sqrt_iter.sv - iterative IEEE-754 square root; FP_SQRT_RNE_EN selects round-to-nearest-even
module fp_sqrt_iter
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] A,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Out,
    output logic         invalid,
    output logic         inexact
);

    localparam int BIAS = bias(EXP_W);
    localparam int N    = MAN_W + 2;
    localparam int CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_t          state_q, state_n;
    op_class_t       cls_q, cls_d;
    logic [W-1:0]    a_q;
    logic [EXP_W-1:0] exp_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    out_q;
    logic            inv_q, inx_q;
    logic            accept;

    logic             a_sign;
    logic [EXP_W-1:0] a_exp;
    logic [MAN_W-1:0] a_frac;
    logic [EXP_W:0]   exp_sum;
    logic             e_odd;
    logic [N-1:0]     radicand;

    logic [MAN_W:0]   root;
    logic             sticky;
    logic [MAN_W-1:0] frac_t, frac_r;
    logic             guard;
    logic [W-1:0]     pack_out;
    logic             pack_inv, pack_inx;

    assign a_sign = a_q[W-1];
    assign a_exp  = a_q[W-2:MAN_W];
    assign a_frac = a_q[MAN_W-1:0];
    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (start) state_n = UNPACK;
            UNPACK:  state_n = ITER;
            ITER:    if (cnt_q == LAST) state_n = PACK;
            PACK:    state_n = DONE;
            DONE:    state_n = start ? UNPACK : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NaN is checked first so a negative NaN is not reported as invalid
    always_comb begin
        cls_d = NORM;
        if (a_exp == '1)      cls_d = (a_frac != '0) ? NAN : (a_sign ? NEG : INF);
        else if (a_exp == '0) cls_d = ZERO;
        else if (a_sign)      cls_d = NEG;
    end

    // BIAS is odd, so e+BIAS is odd exactly when the unbiased exponent is odd,
    // and (e+BIAS)>>1 equals floor(E/2)+BIAS directly.
    always_comb begin
        exp_sum  = {1'b0, a_exp} + (EXP_W+1)'(BIAS);
        e_odd    = exp_sum[0];
        radicand = e_odd ? {1'b1, a_frac, 1'b0} : {2'b01, a_frac};
    end

    sqrt_core #(
        .MAN_W(MAN_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (state_q == UNPACK),
        .en         (state_q == ITER),
        .radicand   (radicand),
        .root       (root),
        .rem_nonzero(sticky)
    );

    always_comb begin
        frac_t = root[MAN_W:1];
        guard  = root[0];
`ifdef FP_SQRT_RNE_EN
        frac_r = frac_t + {{(MAN_W-1){1'b0}}, guard & (sticky | frac_t[0])};
`else
        frac_r = frac_t;
`endif
        pack_out = {1'b0, exp_q, frac_r};
        pack_inv = 1'b0;
        pack_inx = guard | sticky;
        unique case (cls_q)
            ZERO: begin
                pack_out = {a_sign, {(W-1){1'b0}}};
                pack_inx = 1'b0;
            end
            INF: begin
                pack_out = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                pack_inx = 1'b0;
            end
            NAN: begin
                pack_out = QNAN;
                pack_inx = 1'b0;
            end
            NEG: begin
                pack_out = QNAN;
                pack_inv = 1'b1;
                pack_inx = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            cls_q <= ZERO;
            exp_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            inv_q <= 1'b0;
            inx_q <= 1'b0;
        end else begin
            if (accept) a_q <= A;
            if (state_q == UNPACK) begin
                cls_q <= cls_d;
                exp_q <= exp_sum[EXP_W:1];
                cnt_q <= '0;
            end
            if (state_q == ITER) cnt_q <= cnt_q + 1'b1;
            if (state_q == PACK) begin
                out_q <= pack_out;
                inv_q <= pack_inv;
                inx_q <= pack_inx;
            end
        end
    end

    assign busy    = (state_q == UNPACK) || (state_q == ITER) || (state_q == PACK);
    assign done    = (state_q == DONE);
    assign Out     = out_q;
    assign invalid = inv_q;
    assign inexact = inx_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb/tb_fp_sqrt_iter.sv - self-checking bench for fp_sqrt_iter (honours FP_SQRT_RNE_EN)
module tb_fp_sqrt_iter;

    localparam int LAT = 27;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic        busy, done, invalid, inexact;
    logic [31:0] Out;

    int n_cmp = 0;
    int n_err = 0;

    fp_sqrt_iter dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .busy   (busy),
        .done   (done),
        .Out    (Out),
        .invalid(invalid),
        .inexact(inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer square root of the scaled mantissa
    function automatic void ref_sqrt(input logic [31:0] a, output logic [31:0] o,
                                     output logic inv, output logic inx);
        longint unsigned m, x, lo, hi, mid, r;
        int e, ee;
        logic [22:0] fr;
        logic g, st;
        inv = 1'b0;
        inx = 1'b0;
        e = int'(a[30:23]);
        if (e == 255 && a[22:0] != 0) o = 32'h7FC0_0000;
        else if (e == 0)             o = {a[31], 31'b0};
        else if (a[31]) begin
            o = 32'h7FC0_0000;
            inv = 1'b1;
        end else if (e == 255)       o = 32'h7F80_0000;
        else begin
            m  = {41'b0, 1'b1, a[22:0]};
            ee = e - 127;
            if (ee % 2 != 0) begin
                m  = m * 2;
                ee = ee - 1;
            end
            x  = m << 25;
            lo = 0;
            hi = 64'd1 << 26;
            while (hi - lo > 1) begin
                mid = (lo + hi) / 2;
                if (mid * mid <= x) lo = mid;
                else                hi = mid;
            end
            r  = lo;
            n_cmp++;
            assert (r >= (64'd1 << 24) && r < (64'd1 << 25)) else begin
                n_err++;
                $error("FAIL mant_range observed=%h expected=[1,2)", r);
            end
            fr = r[23:1];
            g  = r[0];
            st = (r * r != x);
`ifdef FP_SQRT_RNE_EN
            if (g && (st || fr[0])) fr = fr + 23'd1;
`endif
            o   = {1'b0, 8'(ee / 2 + 127), fr};
            inx = g | st;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input int poke_at, output int lat);
        @(negedge clk);
        start = 1'b1;
        A = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            start = (lat == poke_at);
            if (lat == poke_at) A = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_res(input string tag, input int lat, input logic [31:0] eo,
                             input logic ei, input logic ex);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_out"}, Out, eo);
        chk({tag, "_inv"}, 32'(invalid), 32'(ei));
        chk({tag, "_inx"}, 32'(inexact), 32'(ex));
    endtask

    task automatic verify_op(input string tag, input logic [31:0] a, input int poke_at);
        int lat;
        logic [31:0] eo;
        logic ei, ex;
        ref_sqrt(a, eo, ei, ex);
        run_op(a, poke_at, lat);
        check_res(tag, lat, eo, ei, ex);
    endtask

    logic [31:0] dir_a   [11];
    logic [31:0] dir_o   [11];
    logic        dir_inv [11];
    logic        dir_inx [11];

    initial begin
        int lat, nd;
        logic [31:0] ra;

        dir_a   = '{32'h3F80_0000, 32'h4080_0000, 32'h461C_4000, 32'h4000_0000, 32'h40A0_0000,
                    32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0001, 32'hC080_0000,
                    32'h7FA0_0000};
`ifdef FP_SQRT_RNE_EN
        dir_o   = '{32'h3F80_0000, 32'h4000_0000, 32'h42C8_0000, 32'h3FB5_04F3, 32'h400F_1BBD,
                    32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000,
                    32'h7FC0_0000};
`else
        dir_o   = '{32'h3F80_0000, 32'h4000_0000, 32'h42C8_0000, 32'h3FB5_04F3, 32'h400F_1BBC,
                    32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000,
                    32'h7FC0_0000};
`endif
        dir_inv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        dir_inx = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

        reset = 1'b1;
        start = 1'b0;
        A = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", Out, 32'd0);
        chk("rst_inv", 32'(invalid), 32'd0);
        chk("rst_inx", 32'(inexact), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_op(dir_a[i], -1, lat);
            check_res($sformatf("dir%0d", i), lat, dir_o[i], dir_inv[i], dir_inx[i]);
            @(posedge clk);
            #1;
        end

        run_op(32'h4080_0000, -1, lat);
        check_res("b2b_first", lat, 32'h4000_0000, 1'b0, 1'b0);
        chk("b2b_in_done", 32'(done), 32'd1);
        run_op(32'h3F80_0000, -1, lat);
        check_res("b2b_second", lat, 32'h3F80_0000, 1'b0, 1'b0);

        run_op(32'h4000_0000, 10, lat);
        check_res("poke", lat, 32'h3FB5_04F3, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("out_held", Out, 32'h3FB5_04F3);

        @(negedge clk);
        start = 1'b1;
        A = 32'h4080_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_out", Out, 32'd0);
        chk("abort_inv", 32'(invalid), 32'd0);
        chk("abort_inx", 32'(inexact), 32'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        verify_op("after_abort", 32'h40A0_0000, -1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: ra[30:23] = 8'h00;
                1: ra[30:23] = 8'hFF;
                2: ra[22:0]  = '0;
                default: ra[31] = ($urandom_range(0, 3) == 0);
            endcase
            verify_op($sformatf("rnd%0d_%h", i, ra), ra, (i % 7 == 3) ? 5 + i : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_iter.md
Name: fp_sqrt_iter

Overview:
- Parametrised, single-clock, iterative IEEE-754 square-root unit. It is the successor to the fixed 32-bit multi-clock sqrt.
- Takes one operand on a start pulse and computes one root bit per cycle using a restoring digit recurrence.
- Returns a packed float plus exception flags with a one-cycle done pulse.
- Sits beside the FP adder/multiplier in the floating-point datapath, driven by the same start/done sequencer.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored fraction width, hidden bit excluded.
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- A  in  W  operand {sign, exp, frac}; captured on the accepting edge.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse; Out and flags valid from this cycle.
- Out  out  W  result; held until the next done.
- invalid  out  1  invalid-operation flag; held with Out.
- inexact  out  1  result not exact; held with Out.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, Out=0, invalid=0, inexact=0. Reset during any state aborts the operation; no done is produced.
- States:
  - IDLE: start=1 captures A -> UNPACK; busy=1.
  - UNPACK: classify operand. Unbiased E=e-BIAS. E even: radicand = 1.f. E odd: radicand = 2*(1.f), E=E-1. Result exp = E/2+BIAS. Clear remainder, root, counter -> ITER.
  - ITER: exactly MAN_W+2 cycles, one root bit per cycle (hidden + MAN_W fraction + guard); then -> PACK.
  - PACK: sticky = (remainder != 0). Round, pack, register Out/flags -> DONE.
  - DONE: done=1, busy=0. start=1 in this cycle is accepted (-> UNPACK); otherwise -> IDLE.
- Latency: fixed for all operands, including specials. done is high in the cycle after the (MAN_W+4)th edge following the accepting edge (27 for defaults). Throughput is one op per MAN_W+4 cycles back-to-back.
- start while busy=1: ignored; A changes while busy are ignored.
- Specials (still traverse ITER; result overridden in PACK):
  - ±0 -> ±0.
  - Denormal inputs are flushed to ±0, sign preserved; inexact=0.
  - +inf -> +inf.
  - Negative nonzero (including -inf) -> canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - Any NaN -> canonical qNaN, invalid=0.
- Rounding default is truncation (toward zero). inexact = guard | sticky.
- Root mantissa lies in [1,2); rounding carry into the exponent cannot occur. The bench asserts this.
- Result exponent never under- or overflows for normal inputs.

Optional Feature:
- Macro: FP_SQRT_RNE_EN.
- Defined: round-to-nearest-even in PACK. Increment the fraction when guard & (sticky | lsb). inexact is unchanged.
- Undefined: truncation, and the rounding incrementer is absent.
- Latency is identical in both builds.

Decomposition:
- fp_pkg holds:
  - EXP_W/MAN_W defaults, BIAS function, canonical qNaN constant
  - operand-class enum (ZERO, NORM, INF, NAN, NEG)
  - FSM state enum (IDLE, UNPACK, ITER, PACK, DONE)
- Sub-module sqrt_core, instanced once: restoring recurrence with ports clk, reset, load, radicand, and outputs root, rem_nonzero. It performs one bit per enabled cycle and is parametrised by MAN_W.
- The top level owns the FSM, classification, exponent, rounding and packing.

Test Plan:
- 0x3F800000 (1.0), 0x40800000 (4.0), 0x461C4000 (10000): expect Out = 0x3F800000, 0x40000000, 0x42C80000; inexact=0; done exactly 27 cycles after start.
- 0x40000000 (2.0) -> 0x3FB504F3, inexact=1 in both builds. 0x40A00000 (5.0) -> 0x400F1BBC by default, 0x400F1BBD with FP_SQRT_RNE_EN.
- 0x00000000 -> 0x00000000; 0x80000000 -> 0x80000000; 0x7F800000 -> 0x7F800000; 0x00000001 (denormal) -> 0x00000000; all with flags=0.
- 0xC0800000 (-4.0) -> 0x7FC00000, invalid=1. 0x7FA00000 (sNaN) -> 0x7FC00000, invalid=0.
- Start 4.0 then start 1.0 in its DONE cycle: two done pulses 27 cycles apart with Out 0x40000000 then 0x3F800000. A start pulse mid-ITER is ignored.
- Assert reset at cycle 10 of an operation: all outputs 0 next cycle, no done. A new start afterwards completes normally.
